// File: rtl/dds_sweep_pkg.sv
// Shared types and default widths for the DDS phase-increment sweep scheduler.
package dds_sweep_pkg;

    localparam int DEF_PINC_W  = 32;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_DWELL_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DWELL = 2'd2,
        END   = 2'd3
    } sweep_state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } sweep_dir_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter. Loaded with the dwell length on each accepted word,
// counts while the scheduler sits in DWELL. expire_o is high in the last
// dwell cycle, and combinationally on a load of zero so the scheduler can
// skip DWELL entirely for back-to-back words.
module dds_dwell_timer
    import dds_sweep_pkg::*;
#(
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               count_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q;

    // Load takes priority; counting stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign expire_o = load_i ? (load_val_i == '0) : (cnt_q <= DWELL_W'(1));

endmodule

// File: rtl/dds_sweep_scheduler.sv
// Drives the DDS Compiler s_axis_phase channel through a programmed pinc sweep:
// start word, fixed step, N words per ramp, dwell cycles after each accepted word.
// Optional triangle (up-then-down) sweep is built when SWEEP_TRIANGLE_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | word presented (tvalid=1), held until accepted
// DWELL | tvalid=0, waiting cfg_dwell cycles after an accepted word
// END   | one-cycle completion, done pulse, then IDLE
module dds_sweep_scheduler
    import dds_sweep_pkg::*;
#(
    parameter int PINC_W  = DEF_PINC_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PINC_W-1:0]  cfg_start_pinc,
    input  logic [PINC_W-1:0]  cfg_step_pinc,
    input  logic [CNT_W-1:0]   cfg_num_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_repeat,
`ifdef SWEEP_TRIANGLE_EN
    input  logic               cfg_triangle,
`endif
    input  logic               start,
    input  logic               abort,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
    output logic [PINC_W-1:0]  m_axis_phase_tdata,
    output logic               m_axis_phase_tlast,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   step_idx
);

    // A triangle sweep runs to index 2N-2, which needs one extra bit.
`ifdef SWEEP_TRIANGLE_EN
    localparam int IDX_W = CNT_W + 1;
`else
    localparam int IDX_W = CNT_W;
`endif

    sweep_state_t       state_q;
    logic [PINC_W-1:0]  start_pinc_q;
    logic [PINC_W-1:0]  step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               repeat_q;
    logic [IDX_W-1:0]   last_idx_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PINC_W-1:0]  tdata_q;
    logic               tlast_q;
    logic               tvalid_q;
    logic               busy_q;
    logic               done_q;
    logic               abort_pend_q;
`ifdef SWEEP_TRIANGLE_EN
    logic               tri_q;
    logic [IDX_W-1:0]   turn_idx_q;
    sweep_dir_t         dir_q;
    sweep_dir_t         nxt_dir;
`endif

    logic [CNT_W-1:0]   cfg_nm1;
    logic [IDX_W-1:0]   cfg_last_idx;
    logic               last_word;
    logic [PINC_W-1:0]  nxt_tdata;
    logic [IDX_W-1:0]   nxt_idx;
    logic               nxt_tlast;
    logic               xfer;
    logic               dwell_expire;

    assign cfg_nm1 = (cfg_num_steps == '0) ? '0 : cfg_num_steps - CNT_W'(1);
`ifdef SWEEP_TRIANGLE_EN
    assign cfg_last_idx = cfg_triangle ? {cfg_nm1, 1'b0} : {1'b0, cfg_nm1};
`else
    assign cfg_last_idx = cfg_nm1;
`endif

    assign last_word = (idx_q == last_idx_q);
    assign xfer      = (state_q == SEND) && m_axis_phase_tready;

    // Next word to present: advance along the ramp, or wrap to the start word
    // after the final word (only used when repeating).
    always_comb begin
        nxt_tdata = tdata_q + step_q;
        nxt_idx   = idx_q + IDX_W'(1);
        nxt_tlast = ((idx_q + IDX_W'(1)) == last_idx_q);
`ifdef SWEEP_TRIANGLE_EN
        nxt_dir = dir_q;
        if ((dir_q == DOWN) || (tri_q && (idx_q == turn_idx_q))) begin
            nxt_tdata = tdata_q - step_q;
            nxt_dir   = DOWN;
        end
`endif
        if (last_word) begin
            nxt_tdata = start_pinc_q;
            nxt_idx   = '0;
            nxt_tlast = (last_idx_q == '0);
`ifdef SWEEP_TRIANGLE_EN
            nxt_dir   = UP;
`endif
        end
    end

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (xfer),
        .load_val_i (dwell_q),
        .count_i    (state_q == DWELL),
        .expire_o   (dwell_expire)
    );

    // Sweep sequencer with registered AXIS and status outputs. When repeating,
    // the final word wraps straight back to the start word (END is skipped) so
    // the word period stays dwell+1 across pass boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            start_pinc_q <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            repeat_q     <= 1'b0;
            last_idx_q   <= '0;
            idx_q        <= '0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
            tri_q        <= 1'b0;
            turn_idx_q   <= '0;
            dir_q        <= UP;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        start_pinc_q <= cfg_start_pinc;
                        step_q       <= cfg_step_pinc;
                        dwell_q      <= cfg_dwell;
                        repeat_q     <= cfg_repeat;
                        last_idx_q   <= cfg_last_idx;
`ifdef SWEEP_TRIANGLE_EN
                        tri_q        <= cfg_triangle;
                        turn_idx_q   <= {1'b0, cfg_nm1};
                        dir_q        <= UP;
`endif
                        tdata_q      <= cfg_start_pinc;
                        idx_q        <= '0;
                        tlast_q      <= (cfg_last_idx == '0);
                        tvalid_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        abort_pend_q <= 1'b0;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (xfer) begin
                        if (abort || abort_pend_q) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end else if (!dwell_expire) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            state_q  <= DWELL;
                        end else if (!last_word || repeat_q) begin
                            tdata_q <= nxt_tdata;
                            idx_q   <= nxt_idx;
                            tlast_q <= nxt_tlast;
`ifdef SWEEP_TRIANGLE_EN
                            dir_q   <= nxt_dir;
`endif
                        end else begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= END;
                        end
                    end
                end
                DWELL: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (dwell_expire) begin
                        if (!last_word || repeat_q) begin
                            tdata_q  <= nxt_tdata;
                            idx_q    <= nxt_idx;
                            tlast_q  <= nxt_tlast;
                            tvalid_q <= 1'b1;
`ifdef SWEEP_TRIANGLE_EN
                            dir_q    <= nxt_dir;
`endif
                            state_q  <= SEND;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= END;
                        end
                    end
                end
                END: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_axis_phase_tvalid = tvalid_q;
    assign m_axis_phase_tdata  = tdata_q;
    assign m_axis_phase_tlast  = tlast_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign step_idx            = idx_q[CNT_W-1:0];

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Bench for dds_sweep_scheduler: directed sweeps plus randomized sweeps checked
// against a word-list reference model. Define SWEEP_TRIANGLE_EN to cover triangle mode.
module tb_dds_sweep_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfg_start_pinc = '0;
    logic [31:0] cfg_step_pinc = '0;
    logic [15:0] cfg_num_steps = '0;
    logic [31:0] cfg_dwell = '0;
    logic        cfg_repeat = 1'b0;
    logic        cfg_triangle = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tvalid;
    logic        tready = 1'b1;
    logic [31:0] tdata;
    logic        tlast;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;

    dds_sweep_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .cfg_start_pinc      (cfg_start_pinc),
        .cfg_step_pinc       (cfg_step_pinc),
        .cfg_num_steps       (cfg_num_steps),
        .cfg_dwell           (cfg_dwell),
        .cfg_repeat          (cfg_repeat),
`ifdef SWEEP_TRIANGLE_EN
        .cfg_triangle        (cfg_triangle),
`endif
        .start               (start),
        .abort               (abort),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .m_axis_phase_tdata  (tdata),
        .m_axis_phase_tlast  (tlast),
        .busy                (busy),
        .done                (done),
        .step_idx            (step_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one pass of expected words, consumed by the monitor.
    logic [31:0] exp_data[$];
    int  pos = 0;
    bit  rep_mode = 0;
    int  exp_dwell = 0;
    bit  gap_en = 0;
    int  cyc = 0;
    int  last_hs_cyc = 0;
    bit  last_hs_ok = 0;
    int  hs_count = 0;
    int  done_cnt = 0;
    bit  prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int  rdy_mode = 0;   // 0: ready high, 1: random ready, 2: driven by main sequence

    task automatic build_pass(input logic [31:0] s, input logic [31:0] st, input int n, input bit tri_en);
        int nn;
        int len;
        int m;
        nn  = (n == 0) ? 1 : n;
        len = tri_en ? (2 * nn - 1) : nn;
        exp_data.delete();
        for (int k = 0; k < len; k++) begin
            m = (!tri_en || k < nn) ? k : (2 * (nn - 1) - k);
            exp_data.push_back(s + st * 32'(m));
        end
    endtask

    task automatic arm(input logic [31:0] s, input logic [31:0] st, input int n, input int dw,
                       input bit rep, input bit tri_en, input bit gap);
        cfg_start_pinc = s;
        cfg_step_pinc  = st;
        cfg_num_steps  = 16'(n);
        cfg_dwell      = 32'(dw);
        cfg_repeat     = rep;
        cfg_triangle   = tri_en;
        build_pass(s, st, n, tri_en);
        pos        = 0;
        rep_mode   = rep;
        exp_dwell  = dw;
        gap_en     = gap;
        last_hs_ok = 0;
    endtask

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) tready = ($urandom_range(3) != 0);
        else if (rdy_mode == 0) tready = 1'b1;
    end

    // Monitor: sample half a cycle after the edge; score handshakes, holds and done.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                chk("done_timing", 64'(cyc - last_hs_cyc), 64'(exp_dwell + 1));
                chk("busy_at_done", busy, 1);
            end
            if (prev_stall) begin
                chk("hold_valid", tvalid, 1);
                chk("hold_data", tdata, prev_data);
                chk("hold_last", tlast, prev_last);
            end
            if (tvalid && tready) begin
                if (pos >= exp_data.size()) begin
                    chk("extra_word", 1, 0);
                end else begin
                    chk("tdata", tdata, exp_data[pos]);
                    chk("tlast", tlast, (pos == exp_data.size() - 1));
                    chk("step_idx", step_idx, 64'(pos));
                    pos = rep_mode ? (pos + 1) % exp_data.size() : pos + 1;
                end
                if (gap_en && last_hs_ok) chk("period", 64'(cyc - last_hs_cyc), 64'(exp_dwell + 1));
                last_hs_cyc = cyc;
                last_hs_ok  = 1;
                hs_count++;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic step_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step_cycles(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step_cycles(1);
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step_cycles(1);
            k++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int k = 0;
        while (hs_count < target && k < budget) begin
            step_cycles(1);
            k++;
        end
        chk("hs_wait", (hs_count >= target), 1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!tvalid && k < budget) begin
            step_cycles(1);
            k++;
        end
        chk("valid_wait", tvalid, 1);
    endtask

    task automatic scramble_cfg();
        cfg_start_pinc = $urandom;
        cfg_step_pinc  = $urandom;
        cfg_num_steps  = 16'($urandom_range(0, 7));
        cfg_dwell      = 32'($urandom_range(0, 5));
        cfg_repeat     = 1'($urandom_range(1));
        cfg_triangle   = 1'($urandom_range(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int h0;
        int n;
        int dw;
        int len;
        bit tri_en;
        logic [31:0] s;
        logic [31:0] st;

        // Reset state
        step_cycles(3);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", step_idx, 0);
        reset = 1'b0;
        step_cycles(2);

        // T1: basic ramp with dwell
        arm(32'h51EB85, 32'h51EB85, 4, 2, 0, 0, 1);
        exp_data = '{32'h0051EB85, 32'h00A3D70A, 32'h00F5C28F, 32'h0147AE14};
        d0 = done_cnt;
        pulse_start();
        chk("t1_busy", busy, 1);
        chk("t1_valid", tvalid, 1);
        wait_idle("t1_idle", 100);
        chk("t1_words", 64'(pos), 4);
        chk("t1_done", 64'(done_cnt - d0), 1);

        // T2: backpressure on word 2
        rdy_mode = 2;
        tready = 1'b1;
        arm($urandom, $urandom, 4, 1, 0, 0, 0);
        h0 = hs_count;
        pulse_start();
        wait_hs(h0 + 1, 20);
        tready = 1'b0;
        wait_valid(20);
        chk("t2_idx", step_idx, 1);
        step_cycles(5);
        chk("t2_still_valid", tvalid, 1);
        tready = 1'b1;
        wait_idle("t2_idle", 100);
        chk("t2_words", 64'(pos), 4);

        // T3: wrap with back-to-back words
        rdy_mode = 0;
        arm(32'hFFFFFF00, 32'h100, 2, 0, 0, 0, 1);
        exp_data = '{32'hFFFFFF00, 32'h00000000};
        pulse_start();
        wait_idle("t3_idle", 50);
        chk("t3_words", 64'(pos), 2);

        // T4a: abort during dwell
        arm($urandom, $urandom, 4, 5, 0, 0, 1);
        h0 = hs_count;
        d0 = done_cnt;
        pulse_start();
        wait_hs(h0 + 1, 20);
        step_cycles(2);
        pulse_abort();
        chk("t4a_busy", busy, 0);
        chk("t4a_valid", tvalid, 0);
        step_cycles(8);
        chk("t4a_valid_later", tvalid, 0);
        chk("t4a_no_done", 64'(done_cnt - d0), 0);
        chk("t4a_words", 64'(hs_count - h0), 1);

        // T4b: abort while word is stalled
        rdy_mode = 2;
        tready = 1'b0;
        arm($urandom, $urandom, 3, 1, 0, 0, 0);
        h0 = hs_count;
        d0 = done_cnt;
        pulse_start();
        pulse_abort();
        step_cycles(3);
        chk("t4b_held_valid", tvalid, 1);
        chk("t4b_held_busy", busy, 1);
        tready = 1'b1;
        step_cycles(1);
        chk("t4b_valid", tvalid, 0);
        chk("t4b_busy", busy, 0);
        chk("t4b_words", 64'(hs_count - h0), 1);
        chk("t4b_no_done", 64'(done_cnt - d0), 0);
        rdy_mode = 0;

        // T4c: abort and start together in IDLE
        start = 1'b1;
        abort = 1'b1;
        step_cycles(1);
        start = 1'b0;
        abort = 1'b0;
        chk("t4c_busy", busy, 0);
        chk("t4c_valid", tvalid, 0);

        // T5: repeat with N=0, ignored start, async reset mid-word
        arm($urandom, $urandom, 0, 2, 1, 0, 1);
        h0 = hs_count;
        pulse_start();
        wait_hs(h0 + 3, 40);
        scramble_cfg();
        pulse_start();
        wait_hs(h0 + 6, 40);
        wait_valid(10);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", tvalid, 0);
        chk("t5_rst_busy", busy, 0);
        step_cycles(1);
        reset = 1'b0;
        step_cycles(2);
        chk("t5_after_rst", tvalid, 0);

        // Randomized sweeps
        for (int it = 0; it < 24; it++) begin
            n  = $urandom_range(0, 5);
            dw = $urandom_range(0, 3);
            s  = $urandom;
            st = $urandom;
`ifdef SWEEP_TRIANGLE_EN
            tri_en = 1'($urandom_range(1));
`else
            tri_en = 0;
`endif
            rdy_mode = $urandom_range(1);
            arm(s, st, n, dw, (it % 5 == 4), tri_en, (rdy_mode == 0));
            len = exp_data.size();
            h0 = hs_count;
            d0 = done_cnt;
            pulse_start();
            scramble_cfg();
            step_cycles(1);
            if (busy) pulse_start();
            if (it % 5 == 4) begin
                wait_hs(h0 + 2 * len + 1, 400);
                pulse_abort();
                wait_idle("rnd_rep_idle", 50);
                chk("rnd_rep_no_done", 64'(done_cnt - d0), 0);
            end else begin
                wait_idle("rnd_idle", 400);
                chk("rnd_words", 64'(pos), 64'(len));
                chk("rnd_done", 64'(done_cnt - d0), 1);
            end
        end
        rdy_mode = 0;
        step_cycles(2);

`ifdef SWEEP_TRIANGLE_EN
        // T6: triangle sweep
        arm(32'h100, 32'h100, 3, 1, 0, 1, 1);
        exp_data = '{32'h100, 32'h200, 32'h300, 32'h200, 32'h100};
        pulse_start();
        wait_idle("t6_idle", 100);
        chk("t6_words", 64'(pos), 5);
        arm(32'h100, 32'h100, 1, 0, 0, 1, 1);
        pulse_start();
        wait_idle("t6_n1_idle", 50);
        chk("t6_n1_words", 64'(pos), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
